// File: rtl/ads7254.sv
// rtl/ads7254.sv - ADS7254 frame controller: CS/SCLK generation, SDI config shift, dual SDO capture
module ads7254 #(
   parameter int          HALF_PER = 2,
   parameter logic [15:0] CFG_WORD = 16'h0000,
   parameter int          CS_HOLD  = 4
) (
   input  logic        iCLK_100,
   input  logic        iRST_n,
   input  logic        iSYNC,
   input  logic        iSDOA,
   input  logic        iSDOB,
   output logic        oSDI,
   output logic        oCS_n,
   output logic        oCLK,
   output logic [11:0] odata_ch_A,
   output logic [11:0] odata_ch_B
);

   localparam int DW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
   localparam int HW = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
   localparam logic [DW-1:0] DIV_LAST  = DW'(HALF_PER - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(CS_HOLD - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, HOLD} state_t;

   state_t        state, state_n;
   logic          sync_q1, sync_q2, sync_q3, armed;
   logic [1:0]    init;
   logic          sync_rise;
   logic [DW-1:0] div, div_n;
   logic [5:0]    k, k_n;
   logic [HW-1:0] hcnt, hcnt_n;
   logic [11:0]   sha, sha_n, shb, shb_n, da_n, db_n;
   logic          cs_n_n, clk_n, sdi_n;

   // armed only sets once the synchroniser holds real samples and has seen iSYNC low,
   // so a level already high at reset release never looks like an edge
   always_ff @(posedge iCLK_100 or negedge iRST_n) begin
      if (!iRST_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         sync_q3 <= 1'b0;
         init    <= 2'b00;
         armed   <= 1'b0;
      end else begin
         sync_q1 <= iSYNC;
         sync_q2 <= sync_q1;
         sync_q3 <= sync_q2;
         init    <= {init[0], 1'b1};
         armed   <= armed | (init[1] & ~sync_q2);
      end
   end

   assign sync_rise = armed & sync_q2 & ~sync_q3;

   always_ff @(posedge iCLK_100 or negedge iRST_n) begin
      if (!iRST_n) begin
         state      <= IDLE;
         div        <= '0;
         k          <= '0;
         hcnt       <= '0;
         sha        <= '0;
         shb        <= '0;
         oCS_n      <= 1'b1;
         oCLK       <= 1'b1;
         oSDI       <= 1'b0;
         odata_ch_A <= '0;
         odata_ch_B <= '0;
      end else begin
         state      <= state_n;
         div        <= div_n;
         k          <= k_n;
         hcnt       <= hcnt_n;
         sha        <= sha_n;
         shb        <= shb_n;
         oCS_n      <= cs_n_n;
         oCLK       <= clk_n;
         oSDI       <= sdi_n;
         odata_ch_A <= da_n;
         odata_ch_B <= db_n;
      end
   end

   always_comb begin
      state_n = state;
      div_n   = div;
      k_n     = k;
      hcnt_n  = hcnt;
      sha_n   = sha;
      shb_n   = shb;
      da_n    = odata_ch_A;
      db_n    = odata_ch_B;
      cs_n_n  = oCS_n;
      clk_n   = oCLK;
      sdi_n   = oSDI;
      case (state)
         IDLE: begin
            if (sync_rise) begin
               state_n = SETUP;
               cs_n_n  = 1'b0;
               div_n   = '0;
               k_n     = '0;
               sha_n   = '0;
               shb_n   = '0;
            end
         end
         SETUP: begin
            if (div == DIV_LAST) begin
               state_n = SHIFT;
               div_n   = '0;
               clk_n   = 1'b0;
               sdi_n   = CFG_WORD[15];
            end else begin
               div_n = div + DW'(1);
            end
         end
         SHIFT: begin
            if (div == DIV_LAST) begin
               div_n = '0;
               if (!oCLK) begin
                  // rising edge k+1: every bit is shifted in, only the last 12 survive
                  clk_n = 1'b1;
                  k_n   = k + 6'd1;
                  sha_n = {sha[10:0], iSDOA};
                  shb_n = {shb[10:0], iSDOB};
               end else if (k == 6'd32) begin
                  state_n = DONE;
                  cs_n_n  = 1'b1;
                  sdi_n   = 1'b0;
                  da_n    = sha;
                  db_n    = shb;
               end else begin
                  // falling edge n = k+1 presents CFG_WORD[16-n]
                  clk_n = 1'b0;
                  sdi_n = (k < 6'd16) ? CFG_WORD[4'd15 - k[3:0]] : 1'b0;
               end
            end else begin
               div_n = div + DW'(1);
            end
         end
         DONE: begin
            state_n = HOLD;
            hcnt_n  = '0;
         end
         HOLD: begin
            if (hcnt == HOLD_LAST) state_n = IDLE;
            else                   hcnt_n  = hcnt + HW'(1);
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ads7254.sv
// tb/tb_ads7254.sv - table-driven frame checks plus reset and overlap sequences for ads7254
module tb_ads7254;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sync = 1'b0;
   logic        sdoa = 1'b0;
   logic        sdob = 1'b0;
   logic        sdi, cs_n, sclk;
   logic [11:0] da, db;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] word_a = '0;
   logic [31:0] word_b = '0;
   int          fcnt = 0;

   typedef struct {
      logic [31:0] wa;
      logic [31:0] wb;
      logic [11:0] ea;
      logic [11:0] eb;
      bit          mid;
   } vec_t;

   vec_t vecs[5];

   ads7254 #(.HALF_PER(2), .CFG_WORD(16'h8001), .CS_HOLD(4)) dut (
      .iCLK_100   (clk),
      .iRST_n     (rst_n),
      .iSYNC      (sync),
      .iSDOA      (sdoa),
      .iSDOB      (sdob),
      .oSDI       (sdi),
      .oCS_n      (cs_n),
      .oCLK       (sclk),
      .odata_ch_A (da),
      .odata_ch_B (db)
   );

   always #5 clk = ~clk;

   // ADC model: after falling edge f the lines carry word[32-f]
   always @(negedge sclk or negedge cs_n) begin
      if (sclk) begin
         fcnt = 0;
         sdoa <= 1'b0;
         sdob <= 1'b0;
      end else if (!cs_n && fcnt < 32) begin
         fcnt = fcnt + 1;
         sdoa <= word_a[5'(32 - fcnt)];
         sdob <= word_b[5'(32 - fcnt)];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_frame(input logic [31:0] wa, input logic [31:0] wb,
                            input logic [11:0] ea, input logic [11:0] eb, input bit mid);
      int   lat, low, falls, rises, run, phase_err, sdi_err, stab_err;
      logic prev;
      word_a = wa;
      word_b = wb;
      @(negedge clk);
      sync = 1'b1;
      lat  = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (cs_n && lat < 20);
      check("cs latency", lat, 3);
      low = 0; falls = 0; rises = 0; run = 0; phase_err = 0; sdi_err = 0;
      prev = sclk;
      while (!cs_n && low < 400) begin
         low++;
         if (sclk !== prev) begin
            if (run != 2) phase_err++;
            run = 0;
            if (!sclk) falls++;
            else       rises++;
         end
         run++;
         prev = sclk;
         if (sdi !== ((falls == 1 || falls == 16) ? 1'b1 : 1'b0)) sdi_err++;
         if (low == 10) sync = 1'b0;
         if (mid && low == 60) sync = 1'b1;
         if (mid && low == 70) sync = 1'b0;
         @(negedge clk);
      end
      if (run != 2) phase_err++;
      sync = 1'b0;
      check("cs low length", low, 130);
      check("sclk falls", falls, 32);
      check("sclk rises", rises, 32);
      check("sclk phase lengths", phase_err, 0);
      check("sdi pattern", sdi_err, 0);
      check("sclk idle high", sclk, 1);
      check("sdi idle low", sdi, 0);
      check("data A", da, ea);
      check("data B", db, eb);
      stab_err = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cs_n !== 1'b1 || sclk !== 1'b1 || da !== ea || db !== eb) stab_err++;
      end
      check("idle and stable after frame", stab_err, 0);
   endtask

   initial begin
      int rst_err, lowcnt, t;

      vecs[0] = '{32'h000007FE, 32'h000007FE, 12'h7FE, 12'h7FE, 1'b0};
      vecs[1] = '{32'hFFFFFA5C, 32'h123453F0, 12'hA5C, 12'h3F0, 1'b1};
      vecs[2] = '{32'hFFFFF000, 32'h00000FFF, 12'h000, 12'hFFF, 1'b0};
      vecs[3] = '{32'h00000801, 32'hABCDE400, 12'h801, 12'h400, 1'b0};
      vecs[4] = '{32'h55555555, 32'hAAAAAAAA, 12'h555, 12'hAAA, 1'b1};

      rst_n   = 1'b0;
      rst_err = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         sync = i[1];
         if (cs_n !== 1'b1 || sclk !== 1'b1 || sdi !== 1'b0 || da !== 12'h000 || db !== 12'h000)
            rst_err++;
      end
      check("outputs held in reset", rst_err, 0);

      sync = 1'b1;
      @(negedge clk);
      rst_n  = 1'b1;
      lowcnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cs_n !== 1'b1) lowcnt++;
      end
      check("no frame from sync high at release", lowcnt, 0);
      sync = 1'b0;
      repeat (5) @(negedge clk);

      for (int v = 0; v < 5; v++)
         run_frame(vecs[v].wa, vecs[v].wb, vecs[v].ea, vecs[v].eb, vecs[v].mid);

      word_a = 32'hFFFFFFFF;
      word_b = 32'hFFFFFFFF;
      @(negedge clk);
      sync = 1'b1;
      t = 0;
      while (fcnt != 10 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("reached sclk 10", fcnt, 10);
      #2 rst_n = 1'b0;
      #1;
      check("mid reset cs_n", cs_n, 1);
      check("mid reset sclk", sclk, 1);
      check("mid reset sdi", sdi, 0);
      check("mid reset data A", da, 12'h000);
      check("mid reset data B", db, 12'h000);
      sync = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      run_frame(32'h00000ABC, 32'hFFFFF123, 12'hABC, 12'h123, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
